dcache_miss_ctrl: RTL and testbench
===================================

# dcache_miss_ctrl

Parametrised data-cache controller that sits between the pipeline load/store port, the L1 data array/tag store and the single-port memory. It serves hits combinationally and handles misses with a block-fill FSM. Unlike the previous controller, it merges store data into the fill block on write misses. It also parks a dirty victim in a one-entry writeback buffer, so the fill is read first and the writeback drains in the background while hits proceed.

## Interface
- `ADDR_W`, 32: byte address width.
- `WORD_BYTES`, 4: bytes per pipeline word; power of 2.
- `BLOCK_BYTES`, 16: bytes per cache block; power of 2, ≥ `WORD_BYTES`.
- `CNT_W`, 16: width of the performance counters.
- Derived values:
  - `OFFS_W` = log2(`BLOCK_BYTES`)
  - `BADDR_W` = `ADDR_W` − `OFFS_W`
  - `WIDX` = `addr[OFFS_W-1 : log2(WORD_BYTES)]`
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clock`  in  1  single clock.
  - `reset`  in  1  asynchronous, active-low.
- Pipeline side:
  - `ren`, `wen`  in  1 each  load / store request; a request is valid only when exactly one is high.
  - `addr`  in  `ADDR_W`  byte address.
  - `byte_sel`  in  `WORD_BYTES`  store byte enables.
  - `din`  in  8·`WORD_BYTES`  store data.
  - `stall`  out  1  pipeline hold.
  - `dout`  out  8·`WORD_BYTES`  load data, word `WIDX` of `cache_dout`.
- Cache side:
  - `cache_hit`  in  1  tag hit for `addr`.
  - `cache_dirty`  in  1  victim line dirty.
  - `cache_victim_baddr`  in  `BADDR_W`  victim block address.
  - `cache_dout`  in  8·`BLOCK_BYTES`  hit block on a hit, victim block on a miss.
  - `cache_baddr`  out  `BADDR_W`  block address; `addr` block in IDLE/DRAIN, latched miss block in READ/FILL.
  - `cache_ren`, `cache_wen`  out  1 each  hit read / hit write.
  - `cache_fill`  out  1  write the whole block.
  - `cache_fill_dirty`  out  1  filled line is dirty.
  - `cache_byte_en`  out  `BLOCK_BYTES`  byte enables.
  - `cache_din`  out  8·`BLOCK_BYTES`  write data.
- Memory side:
  - `mem_ren`, `mem_wen`  out  1 each  level requests.
  - `mem_baddr`  out  `BADDR_W`  memory block address.
  - `mem_din`  out  8·`BLOCK_BYTES`  writeback data.
  - `mem_rvalid`  in  1  one-cycle pulse with `mem_dout` valid.
  - `mem_wdone`  in  1  one-cycle pulse, write complete.
  - `mem_dout`  in  8·`BLOCK_BYTES`  read data.
- Status:
  - `miss_cnt`, `wb_cnt`  out  `CNT_W` each  saturating miss and writeback counters.

## Operation
- Definitions: `req` = `ren` XOR `wen`; `miss` = `req` & !`cache_hit`. When `ren` and `wen` are both high, the request is ignored and all outputs are idle.
- States: IDLE, READ, FILL, DRAIN. Registers held outside the state:
  - miss latch: block address, `WIDX`, op, `byte_sel`, `din`.
  - writeback buffer: `wb_valid`, `wb_baddr`, `wb_data`.
- Hit path, IDLE or DRAIN only:
  - `cache_ren` = `ren` & !`wen` & `cache_hit`.
  - `cache_wen` = `wen` & !`ren` & `cache_hit`.
  - `cache_byte_en` = `byte_sel` placed at word `WIDX`, zeros elsewhere.
  - `cache_din` = `din` replicated into every word.
- IDLE:
  - On `miss`: latch the request and increment `miss_cnt`.
  - If `cache_dirty` is also high: load `wb_data`←`cache_dout`, `wb_baddr`←`cache_victim_baddr`, `wb_valid`←1, and increment `wb_cnt`.
  - Then go to READ.
- READ: `mem_ren`=1, `mem_baddr`=latched miss block. On `mem_rvalid`, capture `mem_dout` and go to FILL.
- FILL (one cycle):
  - `cache_fill`=1, `cache_byte_en` all ones, `cache_baddr`=latched miss block.
  - `cache_din` = captured block; for a write miss, bytes of word `WIDX` with latched `byte_sel`=1 are replaced by latched `din`.
  - `cache_fill_dirty` = op is write.
  - Next state is DRAIN if `wb_valid`, else IDLE.
- DRAIN:
  - `mem_wen`=1, `mem_baddr`=`wb_baddr`, `mem_din`=`wb_data`. Hits are served normally.
  - On `mem_wdone`: `wb_valid`←0, go to IDLE.
  - A `miss` in DRAIN waits; it is re-evaluated in IDLE. The memory-read-after-drain order guarantees correct data when the miss targets `wb_baddr`.
- `stall`: 1 in READ and FILL; 1 combinationally in IDLE or DRAIN when `miss` is high; otherwise 0.
- Ignored inputs: `mem_rvalid` outside READ and `mem_wdone` outside DRAIN.
- Counters saturate at all-ones.

## Timing
- Reset, asynchronous: state←IDLE, `wb_valid`←0, counters←0.
  - Registered outputs reset to 0.
  - Combinational outputs follow the IDLE equations.
  - A reset during DRAIN discards the victim; this is accepted.
- Clean read miss, miss at cycle 0:
  - READ from cycle 1; `mem_rvalid` arrives at cycle k.
  - FILL at k+1; IDLE at k+2, where the re-presented request hits and `stall`=0.
- Dirty miss: identical to a clean miss up to FILL; DRAIN starts at k+2 and the pipeline runs unless it misses again.
- Hit: zero added latency, `stall`=0.
- `mem_ren` and `mem_wen` are never high together; `mem_ren` is high only in READ, `mem_wen` only in DRAIN.

## Test plan
- Clean read miss, `addr`=0x100, `mem_rvalid` 3 cycles after READ entry, `mem_dout` word1=0xAABBCCDD:
  - stall high cycles 0..5; cache_fill at cycle 5; replayed load at 0x104 returns 0xAABBCCDD; `miss_cnt`=1.
- Write miss, `addr`=0x208, `byte_sel`=4'b0011, `din`=0x11223344, fill block all 0xFF:
  - FILL `cache_din` word2 = 0xFFFF3344, `cache_fill_dirty`=1.
- Dirty read miss, victim baddr 0x30, victim data pattern P:
  - READ precedes writeback; in DRAIN `mem_wen`=1, `mem_baddr`=0x30, `mem_din`=P; hits during DRAIN complete with `stall`=0; `wb_cnt`=1.
- Miss during DRAIN to the `wb_baddr` block:
  - stall held until `mem_wdone`; then READ of that block returns the written-back data.
- Reset asserted in READ:
  - immediate IDLE; `mem_ren`=0; counters 0; a late `mem_rvalid` is ignored.
- `ren`=`wen`=1 with `cache_hit`=0:
  - no state change, `stall`=0, no counter change.

Source files
------------

// File: rtl/dcache_miss_ctrl_if.sv
// Memory-side bus of the data-cache miss controller.
// Carries the block read request/response and the writeback request/ack
// between the controller (master) and the single-port memory (slave).
//   mem_ren / mem_wen : level read / write requests (master -> slave)
//   mem_baddr         : block address (master -> slave)
//   mem_din           : writeback block data (master -> slave)
//   mem_rvalid        : one-cycle pulse, mem_dout valid (slave -> master)
//   mem_wdone         : one-cycle pulse, write complete (slave -> master)
//   mem_dout          : read block data (slave -> master)
interface dcache_miss_ctrl_if #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 16
);
  localparam int BADDR_W = ADDR_W - $clog2(BLOCK_BYTES);

  logic                     mem_ren;
  logic                     mem_wen;
  logic [BADDR_W-1:0]       mem_baddr;
  logic [8*BLOCK_BYTES-1:0] mem_din;
  logic                     mem_rvalid;
  logic                     mem_wdone;
  logic [8*BLOCK_BYTES-1:0] mem_dout;

  modport master (
    output mem_ren, mem_wen, mem_baddr, mem_din,
    input  mem_rvalid, mem_wdone, mem_dout
  );

  modport slave (
    input  mem_ren, mem_wen, mem_baddr, mem_din,
    output mem_rvalid, mem_wdone, mem_dout
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller between the pipeline load/store port, the L1
// data/tag arrays and a single-port memory. Hits are served combinationally;
// a miss fetches the block (merging store data on a write miss), and a dirty
// victim is parked in a one-entry writeback buffer drained after the fill.
// Ports:
//   clock, reset (async, active-low)
//   pipeline : ren, wen, addr, byte_sel, din -> stall, dout
//   cache    : cache_hit, cache_dirty, cache_victim_baddr, cache_dout ->
//              cache_baddr, cache_ren, cache_wen, cache_fill,
//              cache_fill_dirty, cache_byte_en, cache_din
//   memory   : mem (dcache_miss_ctrl_if.master)
//   status   : miss_cnt, wb_cnt (saturating)
module dcache_miss_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int WORD_BYTES  = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_W       = 16,
  localparam int OFFS_W     = $clog2(BLOCK_BYTES),
  localparam int BADDR_W    = ADDR_W - OFFS_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ren,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [WORD_BYTES-1:0]    byte_sel,
  input  logic [8*WORD_BYTES-1:0]  din,
  output logic                     stall,
  output logic [8*WORD_BYTES-1:0]  dout,
  input  logic                     cache_hit,
  input  logic                     cache_dirty,
  input  logic [BADDR_W-1:0]       cache_victim_baddr,
  input  logic [8*BLOCK_BYTES-1:0] cache_dout,
  output logic [BADDR_W-1:0]       cache_baddr,
  output logic                     cache_ren,
  output logic                     cache_wen,
  output logic                     cache_fill,
  output logic                     cache_fill_dirty,
  output logic [BLOCK_BYTES-1:0]   cache_byte_en,
  output logic [8*BLOCK_BYTES-1:0] cache_din,
  dcache_miss_ctrl_if.master       mem,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         wb_cnt
);
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int BLOCK_W = 8 * BLOCK_BYTES;
  localparam int NWORDS = BLOCK_BYTES / WORD_BYTES;
  localparam int WOFF_W = $clog2(WORD_BYTES);
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, READ, FILL, DRAIN} state_t;

  state_t state, state_nx;

  logic [WIDX_W-1:0]     widx;
  logic                  req, miss;
  logic [BLOCK_BYTES-1:0] hit_be;
  logic [BLOCK_W-1:0]    hit_din, fill_din;

  // miss latch
  logic [BADDR_W-1:0]    m_baddr;
  logic [WIDX_W-1:0]     m_widx;
  logic                  m_write;
  logic [WORD_BYTES-1:0] m_bsel;
  logic [WORD_W-1:0]     m_din;
  logic [BLOCK_W-1:0]    fill_blk;

  // writeback buffer
  logic                  wb_valid;
  logic [BADDR_W-1:0]    wb_baddr;
  logic [BLOCK_W-1:0]    wb_data;

  if (NWORDS > 1) begin : g_widx
    assign widx = addr[OFFS_W-1:WOFF_W];
  end else begin : g_widx_one
    assign widx = '0;
  end

  if (WOFF_W > 0) begin : g_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[WOFF_W-1:0];
  end

  assign req  = ren ^ wen;
  assign miss = req & ~cache_hit;
  assign dout = cache_dout[32'(widx)*WORD_W +: WORD_W];

  // Hit-path write data/enables, and the fill block with store data merged in.
  always_comb begin
    hit_be   = '0;
    hit_din  = {NWORDS{din}};
    fill_din = fill_blk;
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (w == 32'(widx)) hit_be[w*WORD_BYTES +: WORD_BYTES] = byte_sel;
      if (m_write && w == 32'(m_widx)) begin
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
          if (m_bsel[b]) fill_din[w*WORD_W + b*8 +: 8] = m_din[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_nx         = state;
    stall            = 1'b0;
    cache_baddr      = addr[ADDR_W-1:OFFS_W];
    cache_ren        = 1'b0;
    cache_wen        = 1'b0;
    cache_fill       = 1'b0;
    cache_fill_dirty = 1'b0;
    cache_byte_en    = '0;
    cache_din        = '0;
    mem.mem_ren      = 1'b0;
    mem.mem_wen      = 1'b0;
    mem.mem_baddr    = '0;
    mem.mem_din      = '0;
    if (state == IDLE || state == DRAIN) begin
      cache_ren     = ren & ~wen & cache_hit;
      cache_wen     = wen & ~ren & cache_hit;
      cache_byte_en = hit_be;
      cache_din     = hit_din;
      stall         = miss;
    end
    case (state)
      IDLE: if (miss) state_nx = READ;
      READ: begin
        stall         = 1'b1;
        cache_baddr   = m_baddr;
        mem.mem_ren   = 1'b1;
        mem.mem_baddr = m_baddr;
        if (mem.mem_rvalid) state_nx = FILL;
      end
      FILL: begin
        stall            = 1'b1;
        cache_baddr      = m_baddr;
        cache_fill       = 1'b1;
        cache_fill_dirty = m_write;
        cache_byte_en    = '1;
        cache_din        = fill_din;
        state_nx         = wb_valid ? DRAIN : IDLE;
      end
      DRAIN: begin
        // A miss here only stalls; it is accepted once back in IDLE.
        mem.mem_wen   = 1'b1;
        mem.mem_baddr = wb_baddr;
        mem.mem_din   = wb_data;
        if (mem.mem_wdone) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      m_baddr  <= '0;
      m_widx   <= '0;
      m_write  <= 1'b0;
      m_bsel   <= '0;
      m_din    <= '0;
      fill_blk <= '0;
      wb_valid <= 1'b0;
      wb_baddr <= '0;
      wb_data  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (miss) begin
          m_baddr <= addr[ADDR_W-1:OFFS_W];
          m_widx  <= widx;
          m_write <= wen;
          m_bsel  <= byte_sel;
          m_din   <= din;
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
          if (cache_dirty) begin
            wb_valid <= 1'b1;
            wb_baddr <= cache_victim_baddr;
            wb_data  <= cache_dout;
            if (wb_cnt != '1) wb_cnt <= wb_cnt + 1'b1;
          end
        end
        READ:  if (mem.mem_rvalid) fill_blk <= mem.mem_dout;
        DRAIN: if (mem.mem_wdone) wb_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed scenarios followed by random
// loads/stores against a small direct-mapped cache array, a memory and a
// flat golden image of memory contents kept by the bench.
module tb_dcache_miss_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         ren, wen;
  logic [31:0]  addr;
  logic [3:0]   byte_sel;
  logic [31:0]  din;
  logic         stall;
  logic [31:0]  dout;
  logic         cache_hit, cache_dirty;
  logic [27:0]  cache_victim_baddr;
  logic [127:0] cache_dout;
  logic [27:0]  cache_baddr;
  logic         cache_ren, cache_wen, cache_fill, cache_fill_dirty;
  logic [15:0]  cache_byte_en;
  logic [127:0] cache_din;
  logic [15:0]  miss_cnt, wb_cnt;

  dcache_miss_ctrl_if #(.ADDR_W(32), .BLOCK_BYTES(16)) mif ();

  dcache_miss_ctrl #(.ADDR_W(32), .WORD_BYTES(4), .BLOCK_BYTES(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .ren(ren), .wen(wen), .addr(addr), .byte_sel(byte_sel), .din(din),
    .stall(stall), .dout(dout),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty),
    .cache_victim_baddr(cache_victim_baddr), .cache_dout(cache_dout),
    .cache_baddr(cache_baddr), .cache_ren(cache_ren), .cache_wen(cache_wen),
    .cache_fill(cache_fill), .cache_fill_dirty(cache_fill_dirty),
    .cache_byte_en(cache_byte_en), .cache_din(cache_din),
    .mem(mif), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  int total = 0;
  int bad = 0;

  // reference state
  logic [127:0] mem_m [logic [27:0]];
  logic [127:0] gold  [logic [27:0]];
  bit           c_val [4];
  bit           c_dirty [4];
  logic [27:0]  c_tag [4];
  logic [127:0] c_data [4];
  int           rd_cnt = 0;
  int           wr_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] init_blk(input logic [27:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = (32'(b) * 32'h9E3779B1) ^ (32'(w) << 28) ^ 32'h5A5A0F0F;
    return r;
  endfunction

  function automatic logic [127:0] mem_rd(input logic [27:0] b);
    return mem_m.exists(b) ? mem_m[b] : init_blk(b);
  endfunction

  function automatic logic [127:0] gold_rd(input logic [27:0] b);
    return gold.exists(b) ? gold[b] : init_blk(b);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One random-phase clock cycle: cache array and memory respond, bus rules
  // are checked, and array/memory updates are applied at the clock edge.
  task automatic rand_cycle(output logic o_stall, output logic [31:0] o_dout, output logic o_acc);
    int s;
    logic f, fdirty, cw, mw;
    logic [27:0] fb, wa;
    logic [127:0] fd, wd;
    logic [15:0] be;
    s = int'(addr[5:4]);
    cache_hit          = c_val[s] && (c_tag[s] == addr[31:4]);
    cache_dirty        = c_val[s] && c_dirty[s];
    cache_victim_baddr = c_tag[s];
    cache_dout         = c_data[s];
    mif.mem_rvalid = 1'b0;
    mif.mem_wdone  = 1'b0;
    #1;
    if (mif.mem_ren) begin
      if (rd_cnt == 0) begin
        mif.mem_rvalid = 1'b1;
        mif.mem_dout   = mem_rd(mif.mem_baddr);
        rd_cnt = $urandom_range(0, 3);
      end else rd_cnt--;
    end else if ($urandom_range(0, 7) == 0) begin
      mif.mem_rvalid = 1'b1;
      mif.mem_dout   = {$urandom, $urandom, $urandom, $urandom};
    end
    if (mif.mem_wen) begin
      if (wr_cnt == 0) begin
        mif.mem_wdone = 1'b1;
        wr_cnt = $urandom_range(0, 4);
      end else wr_cnt--;
    end else if ($urandom_range(0, 7) == 0) mif.mem_wdone = 1'b1;
    #1;
    chk("mem_excl", mif.mem_ren & mif.mem_wen, 1'b0);
    o_stall = stall;
    o_dout  = dout;
    o_acc   = cache_ren | cache_wen;
    f = cache_fill; fdirty = cache_fill_dirty; fb = cache_baddr; fd = cache_din;
    cw = cache_wen; be = cache_byte_en;
    mw = mif.mem_wen & mif.mem_wdone; wa = mif.mem_baddr; wd = mif.mem_din;
    @(posedge clock);
    if (f) begin
      s = int'(fb[1:0]);
      c_val[s] = 1'b1; c_tag[s] = fb; c_dirty[s] = fdirty; c_data[s] = fd;
    end
    if (cw) begin
      s = int'(fb[1:0]);
      for (int i = 0; i < 16; i++) if (be[i]) c_data[s][i*8 +: 8] = fd[i*8 +: 8];
      c_dirty[s] = 1'b1;
    end
    if (mw) mem_m[wa] = wd;
    #1;
  endtask

  initial begin
    logic [127:0] blk1, pat_p, pat_q, pat_r, pat_s, wr_data, gblk;
    logic [27:0]  b;
    logic         st, acc;
    logic [31:0]  dv;
    int unsigned  w, kind, s;
    int           exp_miss, exp_wb;

    ren = 0; wen = 0; addr = '0; byte_sel = '0; din = '0;
    cache_hit = 0; cache_dirty = 0; cache_victim_baddr = '0; cache_dout = '0;
    mif.mem_rvalid = 0; mif.mem_wdone = 0; mif.mem_dout = '0;
    blk1  = {32'h44444444, 32'h33333333, 32'hAABBCCDD, 32'h11111111};
    pat_p = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    pat_q = 128'h0F0F0F0F_12121212_34343434_56565656;
    pat_r = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    pat_s = 128'h11112222_33334444_55556666_77778888;

    // reset state
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_miss_cnt", miss_cnt, 16'd0);
    chk("rst_wb_cnt", wb_cnt, 16'd0);
    chk("rst_mem_ren", mif.mem_ren, 1'b0);
    chk("rst_mem_wen", mif.mem_wen, 1'b0);
    reset = 1'b1;
    step();

    // clean read miss, rvalid 3 cycles after READ entry
    ren = 1; addr = 32'h100; cache_hit = 0; #1;
    chk("c0_stall", stall, 1'b1);
    chk("c0_baddr", cache_baddr, 28'h10);
    chk("c0_cren", cache_ren, 1'b0);
    step(); chk("c1_stall", stall, 1'b1); chk("c1_mem_ren", mif.mem_ren, 1'b1);
    chk("c1_mem_baddr", mif.mem_baddr, 28'h10);
    step(); chk("c2_stall", stall, 1'b1);
    step(); chk("c3_stall", stall, 1'b1);
    step(); mif.mem_rvalid = 1; mif.mem_dout = blk1; #1; chk("c4_stall", stall, 1'b1);
    step(); mif.mem_rvalid = 0; mif.mem_dout = '0; #1;
    chk("c5_fill", cache_fill, 1'b1); chk("c5_stall", stall, 1'b1);
    chk("c5_din", cache_din, blk1); chk("c5_be", cache_byte_en, 16'hFFFF);
    chk("c5_fdirty", cache_fill_dirty, 1'b0); chk("c5_baddr", cache_baddr, 28'h10);
    chk("c5_mem_ren", mif.mem_ren, 1'b0);
    step(); addr = 32'h104; cache_hit = 1; cache_dout = blk1; #1;
    chk("c6_stall", stall, 1'b0); chk("c6_dout", dout, 32'hAABBCCDD);
    chk("c6_cren", cache_ren, 1'b1); chk("c6_miss_cnt", miss_cnt, 16'd1);

    // write hit path, then write miss with store merge into the fill
    step(); ren = 0; wen = 1; addr = 32'h208; byte_sel = 4'b0011; din = 32'h11223344; #1;
    chk("wh_cwen", cache_wen, 1'b1); chk("wh_be", cache_byte_en, 16'h0300);
    chk("wh_din", cache_din, {4{32'h11223344}}); chk("wh_stall", stall, 1'b0);
    cache_hit = 0; #1; chk("wm_stall", stall, 1'b1);
    step(); mif.mem_rvalid = 1; mif.mem_dout = '1; #1;
    step(); mif.mem_rvalid = 0; #1;
    chk("wm_fill_din", cache_din, {32'hFFFFFFFF, 32'hFFFF3344, 64'hFFFFFFFF_FFFFFFFF});
    chk("wm_fdirty", cache_fill_dirty, 1'b1);
    step(); cache_hit = 1; #1;
    chk("wm_done_stall", stall, 1'b0); chk("wm_miss_cnt", miss_cnt, 16'd2);

    // dirty read miss: read first, writeback drains while hits proceed
    step(); wen = 0; ren = 1; addr = 32'h400; byte_sel = '0; cache_hit = 0;
    cache_dirty = 1; cache_victim_baddr = 28'h30; cache_dout = pat_p; #1;
    chk("dm_stall", stall, 1'b1);
    step(); cache_dirty = 0; cache_dout = '0; #1;
    chk("dm_mem_ren", mif.mem_ren, 1'b1); chk("dm_mem_wen", mif.mem_wen, 1'b0);
    chk("dm_rd_baddr", mif.mem_baddr, 28'h40); chk("dm_wb_cnt", wb_cnt, 16'd1);
    mif.mem_rvalid = 1; mif.mem_dout = pat_q;
    step(); mif.mem_rvalid = 0; #1;
    chk("dm_fill", cache_fill, 1'b1); chk("dm_fill_wen", mif.mem_wen, 1'b0);
    step(); cache_hit = 1; cache_dout = pat_q; #1;
    chk("dr_stall", stall, 1'b0); chk("dr_mem_wen", mif.mem_wen, 1'b1);
    chk("dr_mem_ren", mif.mem_ren, 1'b0); chk("dr_baddr", mif.mem_baddr, 28'h30);
    chk("dr_din", mif.mem_din, pat_p); chk("dr_cren", cache_ren, 1'b1);
    step(); ren = 0; wen = 1; addr = 32'h404; byte_sel = 4'hF; #1;
    chk("dr_wr_stall", stall, 1'b0); chk("dr_cwen", cache_wen, 1'b1);
    step(); wen = 0; mif.mem_wdone = 1; #1; chk("dr_wen_held", mif.mem_wen, 1'b1);
    step(); mif.mem_wdone = 0; #1; chk("dr_end_wen", mif.mem_wen, 1'b0);
    chk("dr_miss_cnt", miss_cnt, 16'd3);

    // miss during DRAIN to the block being written back
    step(); ren = 1; addr = 32'h500; cache_hit = 0; cache_dirty = 1;
    cache_victim_baddr = 28'h60; cache_dout = pat_r; #1;
    step(); cache_dirty = 0; mif.mem_rvalid = 1; mif.mem_dout = pat_s; #1;
    step(); mif.mem_rvalid = 0; #1;
    step(); addr = 32'h600; cache_hit = 0; cache_dout = pat_s; #1;
    chk("md_stall0", stall, 1'b1); chk("md_wen", mif.mem_wen, 1'b1);
    chk("md_baddr", mif.mem_baddr, 28'h60); chk("md_ren", mif.mem_ren, 1'b0);
    step(); chk("md_stall1", stall, 1'b1);
    step(); mif.mem_wdone = 1; wr_data = mif.mem_din; #1; chk("md_stall2", stall, 1'b1);
    step(); mif.mem_wdone = 0; #1;
    chk("md_idle_stall", stall, 1'b1); chk("md_idle_wen", mif.mem_wen, 1'b0);
    chk("md_idle_ren", mif.mem_ren, 1'b0);
    step(); chk("md_rd_ren", mif.mem_ren, 1'b1); chk("md_rd_baddr", mif.mem_baddr, 28'h60);
    chk("md_miss_cnt", miss_cnt, 16'd5);
    mif.mem_rvalid = 1; mif.mem_dout = wr_data;
    step(); mif.mem_rvalid = 0; #1;
    chk("md_fill_din", cache_din, pat_r); chk("md_fdirty", cache_fill_dirty, 1'b0);
    step(); cache_hit = 1; #1;
    chk("md_done_stall", stall, 1'b0); chk("md_wb_cnt", wb_cnt, 16'd2);

    // reset while in READ; a late rvalid must be ignored
    step(); addr = 32'h700; cache_hit = 0; #1;
    step(); chk("rr_mem_ren", mif.mem_ren, 1'b1);
    reset = 0; ren = 0; #1;
    chk("rr_mem_ren_off", mif.mem_ren, 1'b0); chk("rr_stall", stall, 1'b0);
    chk("rr_miss_cnt", miss_cnt, 16'd0); chk("rr_wb_cnt", wb_cnt, 16'd0);
    #1 reset = 1; mif.mem_rvalid = 1; mif.mem_dout = '1;
    step(); mif.mem_rvalid = 0; #1;
    chk("rr_late_ren", mif.mem_ren, 1'b0); chk("rr_late_fill", cache_fill, 1'b0);

    // ren and wen both high on a miss: ignored
    ren = 1; wen = 1; addr = 32'h800; cache_hit = 0; #1;
    chk("bw_stall", stall, 1'b0); chk("bw_cren", cache_ren, 1'b0);
    chk("bw_cwen", cache_wen, 1'b0);
    step(); chk("bw_mem_ren", mif.mem_ren, 1'b0); chk("bw_miss_cnt", miss_cnt, 16'd0);
    ren = 0; wen = 0;

    // random loads/stores against the reference cache, memory and golden image
    exp_miss = 0; exp_wb = 0;
    for (int i = 0; i < 4; i++) begin
      c_val[i] = 0; c_dirty[i] = 0; c_tag[i] = '0; c_data[i] = '0;
    end
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      b = 28'($urandom_range(0, 11));
      w = $urandom_range(0, 3);
      addr = {b, 2'(w), 2'b00};
      din = $urandom;
      byte_sel = 4'($urandom_range(1, 15));
      if (kind == 0) begin
        ren = 1; wen = 1;
        rand_cycle(st, dv, acc);
        chk("rnd_both_stall", st, 1'b0);
        chk("rnd_both_acc", acc, 1'b0);
      end else begin
        ren = (kind <= 5); wen = !ren;
        s = int'(b[1:0]);
        if (!(c_val[s] && c_tag[s] == b)) begin
          exp_miss++;
          if (c_val[s] && c_dirty[s]) exp_wb++;
        end
        st = 1'b1;
        for (int c = 0; c < 40 && st; c++) rand_cycle(st, dv, acc);
        chk("rnd_req_done", st, 1'b0);
        if (!st) begin
          chk("rnd_access", acc, 1'b1);
          gblk = gold_rd(b);
          if (ren) chk("rnd_load", dv, gblk[w*32 +: 32]);
          else begin
            for (int i = 0; i < 4; i++)
              if (byte_sel[i]) gblk[w*32 + i*8 +: 8] = din[i*8 +: 8];
            gold[b] = gblk;
          end
        end
      end
      ren = 0; wen = 0;
      for (int k = $urandom_range(0, 2); k > 0; k--) rand_cycle(st, dv, acc);
    end
    for (int c = 0; c < 40 && mif.mem_wen; c++) rand_cycle(st, dv, acc);
    chk("rnd_drained", mif.mem_wen, 1'b0);
    chk("rnd_miss_cnt", miss_cnt, 16'(exp_miss));
    chk("rnd_wb_cnt", wb_cnt, 16'(exp_wb));
    for (int i = 0; i < 12; i++) begin
      b = 28'(i);
      s = int'(b[1:0]);
      if (c_val[s] && c_tag[s] == b) chk("end_cache_blk", c_data[s], gold_rd(b));
      else chk("end_mem_blk", mem_rd(b), gold_rd(b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
